// File: rtl/secuenciador_bus_rtc_if.sv
// Signal bundle between the read/write control FSMs, the bus sequencer and the
// RTC pad buffer.
//
// Handshake: `start` (with rw/addr/burst_len) is a request that the sequencer
// samples on a rising edge only while it is idle (busy=0). A request that is
// present while busy is dropped, not queued. `done` pulses for one cycle when a
// transaction ends. `beat_req` pulses once per beat; the requester then has
// T_SETUP+T_CS+T_HOLD cycles to place that beat's write data on `wr_data`.
//
// Modports:
//   master - control FSM / pad side: drives the request, write data and bus_in.
//   slave  - the sequencer: drives the RTC strobes, pad controls, read data,
//            status and the state_dbg observation port.
interface secuenciador_bus_rtc_if #(
  parameter int DATA_W = 8,
  parameter int BL_W   = 3
);
  logic              start;
  logic              rw;
  logic [DATA_W-1:0] addr;
  logic [BL_W-1:0]   burst_len;
  logic [DATA_W-1:0] wr_data;
  logic              beat_req;
  logic [DATA_W-1:0] bus_in;
  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;
  logic              cs_n;
  logic              wr_n;
  logic              rd_n;
  logic              ad_n;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              done;
  logic [2:0]        state_dbg;

  modport master (
    output start, rw, addr, burst_len, wr_data, bus_in,
    input  beat_req, bus_out, bus_oe, cs_n, wr_n, rd_n, ad_n,
    input  rd_data, rd_valid, busy, done, state_dbg
  );

  modport slave (
    input  start, rw, addr, burst_len, wr_data, bus_in,
    output beat_req, bus_out, bus_oe, cs_n, wr_n, rd_n, ad_n,
    output rd_data, rd_valid, busy, done, state_dbg
  );
endinterface

// File: rtl/secuenciador_bus_rtc.sv
// Bus-cycle sequencer for a multiplexed address/data parallel RTC bus.
//
// Each beat is: address setup (ad_n low, address driven), address strobe
// (cs_n/wr_n low), address hold, gap (cs_n high, write data driven or bus
// released for a read), data strobe (cs_n plus wr_n or rd_n low) and data hold.
// Every phase length is a parameter; one 8-bit down-counter times them all.
// Bursts repeat the beat up to BURST_MAX times.
//
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-low reset
//   bif   - secuenciador_bus_rtc_if.slave: request/done handshake, write data,
//           beat_req, pad signals (bus_in/bus_out/bus_oe), RTC strobes
//           (cs_n/wr_n/rd_n/ad_n), read data (rd_data/rd_valid), busy and
//           state_dbg (current FSM state encoding).
//
// Build option:
//   SECUENCIADOR_ADDR_INC_EN defined - each burst beat addresses previous + 1.
//   undefined                        - every beat reuses the sampled address.
// All outputs are registered: next values are derived from the next state.
module secuenciador_bus_rtc #(
  parameter int DATA_W    = 8,
  parameter int T_SETUP   = 1,
  parameter int T_CS      = 6,
  parameter int T_HOLD    = 1,
  parameter int T_GAP     = 12,
  parameter int BURST_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  secuenciador_bus_rtc_if.slave bif
);
  localparam int BL_W = $clog2(BURST_MAX + 1);

  if (T_SETUP < 1 || T_SETUP > 255 || T_CS < 1 || T_CS > 255 ||
      T_HOLD < 1 || T_HOLD > 255 || T_GAP < 1 || T_GAP > 255) begin : g_bad_timing
    $error("secuenciador_bus_rtc: timing parameters must be in 1..255");
  end

  // Counter reload values: a phase of T cycles counts T-1 down to 0.
  localparam logic [7:0] C_SETUP = 8'(T_SETUP - 1);
  localparam logic [7:0] C_CS    = 8'(T_CS - 1);
  localparam logic [7:0] C_HOLD  = 8'(T_HOLD - 1);
  localparam logic [7:0] C_GAP   = 8'(T_GAP - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ADDR_SETUP  = 3'd1,
    ADDR_STROBE = 3'd2,
    ADDR_HOLD   = 3'd3,
    GAP         = 3'd4,
    DATA_STROBE = 3'd5,
    DATA_HOLD   = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [BL_W-1:0]   beats_q, beats_d;   // beats still to run after the current one
  logic [DATA_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic [DATA_W-1:0] bus_out_q, bus_out_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              cs_n_q, wr_n_q, rd_n_q, ad_n_q, bus_oe_q, busy_q;
  logic              cs_n_d, wr_n_d, rd_n_d, ad_n_d, bus_oe_d, busy_d;
  logic              beat_req_q, done_q, rd_valid_q;
  logic              beat_req_d, done_d, rd_valid_d;
  logic [BL_W-1:0]   len_eff;
  logic [DATA_W-1:0] next_addr;

  // 0 beats means 1; anything above BURST_MAX is clamped.
  always_comb begin
    len_eff = bif.burst_len;
    if (bif.burst_len == '0)
      len_eff = BL_W'(1);
    else if (bif.burst_len > BL_W'(BURST_MAX))
      len_eff = BL_W'(BURST_MAX);
  end

`ifdef SECUENCIADOR_ADDR_INC_EN
  assign next_addr = addr_q + DATA_W'(1);  // wraps modulo 2^DATA_W
`else
  assign next_addr = addr_q;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = (state_q == IDLE) ? cnt_q : cnt_q - 8'd1;
    beats_d    = beats_q;
    addr_d     = addr_q;
    rd_d       = rd_q;
    bus_out_d  = bus_out_q;
    rd_data_d  = rd_data_q;
    beat_req_d = 1'b0;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;

    case (state_q)
      IDLE: if (bif.start) begin
        state_d    = ADDR_SETUP;
        cnt_d      = C_SETUP;
        addr_d     = bif.addr;
        rd_d       = bif.rw;
        beats_d    = len_eff - BL_W'(1);
        bus_out_d  = bif.addr;
        beat_req_d = 1'b1;
      end
      ADDR_SETUP: if (cnt_q == 8'd0) begin
        state_d = ADDR_STROBE;
        cnt_d   = C_CS;
      end
      ADDR_STROBE: if (cnt_q == 8'd0) begin
        state_d = ADDR_HOLD;
        cnt_d   = C_HOLD;
      end
      ADDR_HOLD: if (cnt_q == 8'd0) begin
        state_d = GAP;
        cnt_d   = C_GAP;
        if (!rd_q) bus_out_d = bif.wr_data;
      end
      GAP: if (cnt_q == 8'd0) begin
        state_d = DATA_STROBE;
        cnt_d   = C_CS;
      end
      DATA_STROBE: if (cnt_q == 8'd0) begin
        state_d = DATA_HOLD;
        cnt_d   = C_HOLD;
        // Capture on the edge that closes the read strobe.
        if (rd_q) begin
          rd_data_d  = bif.bus_in;
          rd_valid_d = 1'b1;
        end
      end
      DATA_HOLD: if (cnt_q == 8'd0) begin
        if (beats_q != '0) begin
          state_d    = ADDR_SETUP;
          cnt_d      = C_SETUP;
          beats_d    = beats_q - BL_W'(1);
          addr_d     = next_addr;
          bus_out_d  = next_addr;
          beat_req_d = 1'b1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Level outputs follow the state being entered.
    ad_n_d   = !(state_d == ADDR_SETUP || state_d == ADDR_STROBE || state_d == ADDR_HOLD);
    cs_n_d   = !(state_d == ADDR_STROBE || state_d == DATA_STROBE);
    wr_n_d   = !(state_d == ADDR_STROBE || (state_d == DATA_STROBE && !rd_d));
    rd_n_d   = !(state_d == DATA_STROBE && rd_d);
    bus_oe_d = !ad_n_d ||
               (!rd_d && (state_d == GAP || state_d == DATA_STROBE || state_d == DATA_HOLD));
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      beats_q    <= '0;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      bus_out_q  <= '0;
      rd_data_q  <= '0;
      cs_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      ad_n_q     <= 1'b1;
      bus_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      beat_req_q <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      beats_q    <= beats_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      bus_out_q  <= bus_out_d;
      rd_data_q  <= rd_data_d;
      cs_n_q     <= cs_n_d;
      wr_n_q     <= wr_n_d;
      rd_n_q     <= rd_n_d;
      ad_n_q     <= ad_n_d;
      bus_oe_q   <= bus_oe_d;
      busy_q     <= busy_d;
      beat_req_q <= beat_req_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bif.cs_n      = cs_n_q;
  assign bif.wr_n      = wr_n_q;
  assign bif.rd_n      = rd_n_q;
  assign bif.ad_n      = ad_n_q;
  assign bif.bus_oe    = bus_oe_q;
  assign bif.bus_out   = bus_out_q;
  assign bif.rd_data   = rd_data_q;
  assign bif.rd_valid  = rd_valid_q;
  assign bif.busy      = busy_q;
  assign bif.done      = done_q;
  assign bif.beat_req  = beat_req_q;
  assign bif.state_dbg = state_q;
endmodule

// File: tb/tb_secuenciador_bus_rtc.sv
// Directed bench for secuenciador_bus_rtc with default timing (beat = 27 cycles).
// Cycle n below is the interval right after the n-th rising edge counted from
// the edge that samples start (edge 0), so cycle 1 is the first busy cycle.
module tb_secuenciador_bus_rtc;
  logic clk = 1'b0;
  logic reset = 1'b0;

  secuenciador_bus_rtc_if #(.DATA_W(8), .BL_W(3)) bif ();

  secuenciador_bus_rtc dut (
    .clk   (clk),
    .reset (reset),
    .bif   (bif)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];     // expected address at each beat_req
  logic [7:0] exp_rd_q[$];  // expected rd_data at each rd_valid
  logic [7:0] rd_base;
  int br_cnt;
  int rv_cyc[$];
  int done_cyc[$];
  logic cs_a[0:127], wr_a[0:127], rd_a[0:127], ad_a[0:127], oe_a[0:127], busy_a[0:127];
  logic [7:0] bo_a[0:127];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      $error("%s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] beat_addr(input logic [7:0] a, input int k);
`ifdef SECUENCIADOR_ADDR_INC_EN
    return a + 8'(k);
`else
    return (k >= 0) ? a : 8'h00;
`endif
  endfunction

  task automatic check_reset(input string pfx);
    check({pfx, " cs_n"},      bif.cs_n, 1);
    check({pfx, " wr_n"},      bif.wr_n, 1);
    check({pfx, " rd_n"},      bif.rd_n, 1);
    check({pfx, " ad_n"},      bif.ad_n, 1);
    check({pfx, " bus_oe"},    bif.bus_oe, 0);
    check({pfx, " busy"},      bif.busy, 0);
    check({pfx, " done"},      bif.done, 0);
    check({pfx, " rd_valid"},  bif.rd_valid, 0);
    check({pfx, " beat_req"},  bif.beat_req, 0);
    check({pfx, " bus_out"},   bif.bus_out, 0);
    check({pfx, " rd_data"},   bif.rd_data, 0);
    check({pfx, " state_dbg"}, bif.state_dbg, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic launch(input logic r, input logic [7:0] a, input logic [2:0] len);
    @(negedge clk);
    bif.rw = r;
    bif.addr = a;
    bif.burst_len = len;
    bif.start = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Samples cycles 1..n, running the address/read-data scoreboard as it goes.
  // start is held high through cycle start_until.
  task automatic capture(input int n, input int start_until);
    br_cnt = 0;
    rv_cyc.delete();
    done_cyc.delete();
    for (int c = 1; c <= n; c++) begin
      cs_a[c] = bif.cs_n;
      wr_a[c] = bif.wr_n;
      rd_a[c] = bif.rd_n;
      ad_a[c] = bif.ad_n;
      oe_a[c] = bif.bus_oe;
      busy_a[c] = bif.busy;
      bo_a[c] = bif.bus_out;
      if (bif.beat_req) begin
        bif.bus_in = rd_base + 8'(br_cnt);
        br_cnt++;
        check("beat addr queue nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check($sformatf("beat addr c%0d", c), bif.bus_out, exp_q.pop_front());
      end
      if (bif.rd_valid) begin
        rv_cyc.push_back(c);
        check("rd queue nonempty", exp_rd_q.size() != 0, 1);
        if (exp_rd_q.size() != 0) check($sformatf("rd_data c%0d", c), bif.rd_data, exp_rd_q.pop_front());
      end
      if (bif.done) done_cyc.push_back(c);
      bif.start = (c <= start_until);
      @(posedge clk);
      #1;
    end
    bif.start = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bif.start = 1'b0;
    bif.rw = 1'b0;
    bif.addr = 8'h00;
    bif.burst_len = 3'd0;
    bif.wr_data = 8'h00;
    bif.bus_in = 8'h00;
    rd_base = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    reset = 1'b1;

    // Single write 0x59 to 0x21.
    bif.wr_data = 8'h59;
    exp_q.push_back(8'h21);
    launch(1'b0, 8'h21, 3'd1);
    capture(28, 0);
    for (int c = 1; c <= 28; c++) begin
      check($sformatf("wr cs_n c%0d", c), cs_a[c], !((c >= 2 && c <= 7) || (c >= 21 && c <= 26)));
      check($sformatf("wr wr_n c%0d", c), wr_a[c], !((c >= 2 && c <= 7) || (c >= 21 && c <= 26)));
      check($sformatf("wr rd_n c%0d", c), rd_a[c], 1);
      check($sformatf("wr ad_n c%0d", c), ad_a[c], !(c <= 8));
      check($sformatf("wr bus_oe c%0d", c), oe_a[c], (c <= 27));
      check($sformatf("wr busy c%0d", c), busy_a[c], (c <= 27));
      if (c <= 8) check($sformatf("wr addr c%0d", c), bo_a[c], 8'h21);
      else if (c <= 27) check($sformatf("wr data c%0d", c), bo_a[c], 8'h59);
    end
    check("wr done count", done_cyc.size(), 1);
    check("wr done cycle", done_cyc[0], 28);
    check("wr beat count", br_cnt, 1);

    // Single read of 0xA5 from 0x30.
    rd_base = 8'hA5;
    exp_q.push_back(8'h30);
    exp_rd_q.push_back(8'hA5);
    launch(1'b1, 8'h30, 3'd1);
    capture(28, 0);
    for (int c = 1; c <= 28; c++) begin
      check($sformatf("rd rd_n c%0d", c), rd_a[c], !(c >= 21 && c <= 26));
      check($sformatf("rd wr_n c%0d", c), wr_a[c], !(c >= 2 && c <= 7));
      check($sformatf("rd cs_n c%0d", c), cs_a[c], !((c >= 2 && c <= 7) || (c >= 21 && c <= 26)));
      check($sformatf("rd bus_oe c%0d", c), oe_a[c], (c <= 8));
    end
    check("rd valid count", rv_cyc.size(), 1);
    check("rd valid cycle", rv_cyc[0], 27);
    check("rd done cycle", done_cyc[0], 28);

    // Burst read of 4 beats from 0xFE, distinct byte per beat.
    rd_base = 8'hC0;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(beat_addr(8'hFE, k));
      exp_rd_q.push_back(8'hC0 + 8'(k));
    end
    launch(1'b1, 8'hFE, 3'd4);
    capture(109, 0);
    check("burst rd beats", br_cnt, 4);
    check("burst rd valid count", rv_cyc.size(), 4);
    for (int k = 0; k < rv_cyc.size(); k++)
      check($sformatf("burst rd valid %0d cycle", k), rv_cyc[k], 27 + 27 * k);
    check("burst rd done count", done_cyc.size(), 1);
    check("burst rd done cycle", done_cyc[0], 109);
    check("burst rd busy c108", busy_a[108], 1);

    // Burst write of 3 beats at 0x10.
    bif.wr_data = 8'h77;
    for (int k = 0; k < 3; k++) exp_q.push_back(beat_addr(8'h10, k));
    launch(1'b0, 8'h10, 3'd3);
    capture(82, 0);
    check("burst3 beats", br_cnt, 3);
    check("burst3 done cycle", done_cyc[0], 82);
    check("burst3 data c75", bo_a[75], 8'h77);

    // burst_len 7 clamps to 4 beats.
    for (int k = 0; k < 4; k++) exp_q.push_back(beat_addr(8'h80, k));
    launch(1'b0, 8'h80, 3'd7);
    capture(112, 0);
    check("clamp beats", br_cnt, 4);
    check("clamp done count", done_cyc.size(), 1);
    check("clamp done cycle", done_cyc[0], 109);

    // burst_len 0 runs one beat.
    exp_q.push_back(8'h33);
    launch(1'b0, 8'h33, 3'd0);
    capture(30, 0);
    check("len0 beats", br_cnt, 1);
    check("len0 done cycle", done_cyc[0], 28);

    // start held through busy and the done cycle: exactly one restart.
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h44);
    launch(1'b0, 8'h44, 3'd1);
    capture(58, 28);
    check("hs beats", br_cnt, 2);
    check("hs done count", done_cyc.size(), 2);
    check("hs done first", done_cyc[0], 28);
    check("hs done second", done_cyc[1], 56);
    check("hs busy c28", busy_a[28], 0);
    check("hs ad_n c28", ad_a[28], 1);
    check("hs ad_n c29", ad_a[29], 0);
    check("hs busy c29", busy_a[29], 1);

    // Reset in cycle 15 of a 2-beat write.
    exp_q.push_back(8'h5A);
    launch(1'b0, 8'h5A, 3'd2);
    capture(14, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_reset("midrst");
    check("midrst done count", done_cyc.size(), 0);
    check("midrst addr queue empty", exp_q.size(), 0);
    reset = 1'b1;

    // Fresh read after reset keeps nominal timing.
    rd_base = 8'h3C;
    exp_q.push_back(8'h06);
    exp_rd_q.push_back(8'h3C);
    launch(1'b1, 8'h06, 3'd1);
    capture(28, 0);
    check("post rst valid count", rv_cyc.size(), 1);
    check("post rst valid cycle", rv_cyc[0], 27);
    check("post rst done cycle", done_cyc[0], 28);
    check("post rst ad_n c1", ad_a[1], 0);
    check("post rst rd queue empty", exp_rd_q.size(), 0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/secuenciador_bus_rtc.md
# secuenciador_bus_rtc

- Parametrised bus-cycle sequencer for a multiplexed address/data parallel RTC bus.
- Generates `cs_n`, `wr_n`, `rd_n`, `ad_n` and tristate control for single or burst read/write transactions, with every timing interval set by parameter.
- Takes a start/done handshake from the read/write control FSMs and captures read data.
- Sits between those FSMs and the bidirectional RTC pad buffer.

## Interface
- `DATA_W`, 8: address/data bus width.
- `T_SETUP`, 1: cycles `ad_n` is low before `cs_n` falls, address phase.
- `T_CS`, 6: `cs_n` strobe low width, both phases.
- `T_HOLD`, 1: cycles after the strobe rises during which bus and `ad_n` state are held.
- `T_GAP`, 12: `cs_n` high time between the address and data phases.
- `BURST_MAX`, 4: maximum beats per transaction.
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `start` in 1: transaction request; sampled only when `busy`=0.
- `rw` in 1: 1 = read, 0 = write; sampled with `start`.
- `addr` in DATA_W: first register address; sampled with `start`.
- `burst_len` in clog2(BURST_MAX+1): number of beats; 0 is treated as 1, values above BURST_MAX are clamped to BURST_MAX.
- `wr_data` in DATA_W: write data for the current beat.
- `beat_req` out 1: one-cycle pulse at the start of each beat.
- `bus_in` in DATA_W: pad input.
- `bus_out` out DATA_W: pad output value.
- `bus_oe` out 1: pad tristate enable (1 = drive).
- `cs_n`, `wr_n`, `rd_n`, `ad_n` out 1 each: RTC control strobes.
- `rd_data` out DATA_W: captured read byte.
- `rd_valid` out 1: one-cycle pulse when `rd_data` updates.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle pulse on transaction completion.

## Operation
- FSM states: IDLE, ADDR_SETUP, ADDR_STROBE, ADDR_HOLD, GAP, DATA_STROBE, DATA_HOLD.
- The states last T_SETUP, T_CS, T_HOLD, T_GAP, T_CS and T_HOLD cycles respectively, timed by one 8-bit down-counter. Timing parameters must be in the range 1..255; anything outside that range is an elaboration error.
- All outputs are registered. Reset values:
  - `cs_n`, `wr_n`, `rd_n`, `ad_n` = 1.
  - `bus_oe`, `busy`, `done`, `rd_valid`, `beat_req` = 0.
  - `bus_out`, `rd_data` = 0.
- Outputs by state:
  - **ADDR_SETUP**: `ad_n`=0, `bus_oe`=1, `bus_out`=current address, `beat_req` pulses in the first cycle.
  - **ADDR_STROBE**: as ADDR_SETUP, plus `cs_n`=0 and `wr_n`=0.
  - **ADDR_HOLD**: `cs_n`=1, `wr_n`=1; `ad_n`=0 and the bus are held.
  - **GAP**: `ad_n`=1. For a write, `bus_oe`=1 and `bus_out`=`wr_data`. For a read, `bus_oe`=0.
  - **DATA_STROBE**: `cs_n`=0, and `wr_n`=0 (write) or `rd_n`=0 (read). Write data stays driven.
  - **DATA_HOLD**: all strobes high. A write keeps the bus driven; a read keeps `bus_oe`=0.
- `wr_data` is registered on the edge that enters GAP. Upstream must present it within T_SETUP+T_CS+T_HOLD cycles of `beat_req`.
- Read capture: `bus_in` is registered on the edge that ends the last DATA_STROBE cycle; `rd_valid` pulses in the first DATA_HOLD cycle.
- After DATA_HOLD:
  - If beats remain, go to ADDR_SETUP with the next address.
  - Otherwise go to IDLE with `done`=1 and `busy`=0 in that cycle.
- Address arithmetic is modulo 2^DATA_W, so 0xFF+1 = 0x00.
- `start` while `busy`=1 is ignored. A `start` in the `done` cycle is accepted, so transactions can run back-to-back.
- `reset` low in any state: at the next edge all outputs and the FSM return to reset values. No `done` pulse and no partial `rd_valid` are produced.

## Timing
- Cycle 0 is the edge that samples `start`. `ad_n` falls and `busy` rises at cycle 1.
- Beat length L = T_SETUP + 2·T_CS + 2·T_HOLD + T_GAP. With the default parameters L = 27.
- Beat k (k counted from 0) begins at cycle 1 + k·L.
- `done` is asserted at cycle 1 + N·L for N beats. Latency for a single default beat is 28 cycles.
- Address strobe `cs_n` is low in cycles 1+T_SETUP .. T_SETUP+T_CS of each beat.
- Write data is driven for T_GAP + T_CS + T_HOLD cycles around the data strobe, giving 19 cycles of setup and hold with the defaults.

## Configuration
- `SECUENCIADOR_ADDR_INC_EN` defined: each burst beat uses the previous address + 1, for sequential register access.
- Undefined: every beat reuses the sampled `addr`, for repeated polling of one register.
- The macro changes only the next-address logic; beat timing is unchanged.

## Test plan
- Single write: `addr`=0x21, `wr_data`=0x59, `burst_len`=1 -> `bus_out`=0x21 under `ad_n`=0; `cs_n`/`wr_n` low in cycles 2–7 and 21–26; `bus_out`=0x59 during the data strobe; `done` at cycle 28.
- Single read: `bus_in`=0xA5 -> `rd_n` low in cycles 21–26, `wr_n` high throughout; `rd_data`=0xA5 with `rd_valid` at cycle 27; `bus_oe`=0 from cycle 9 on.
- Burst read: `burst_len`=4, `addr`=0xFE, INC_EN defined -> addresses 0xFE, 0xFF, 0x00, 0x01; four `rd_valid` pulses spaced by 27 cycles; `done` at cycle 109.
- Burst without INC_EN: `burst_len`=3, `addr`=0x10 -> 0x10 on all beats. `burst_len`=7 -> clamped to 4 beats. `burst_len`=0 -> 1 beat.
- Handshake: `start` held during `busy` -> ignored; `start` in the `done` cycle -> new transaction, `ad_n` low on the next cycle.
- Reset mid-op: `reset`=0 at cycle 15 -> all outputs return to reset values at the next edge; no `done`; a fresh `start` then produces nominal timing.
